// File: rtl/comm_ctrl_pkg.sv
// Shared definitions for the comm_ctrl slice: state encodings and width defaults,
// so LED/display logic decodes the state bus identically to the controller.
package comm_ctrl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int DROP_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COMM_F = 3'd1,
        S_COMM_T = 3'd2,
        S_DRAIN  = 3'd3,
        S_HOLD_F = 3'd4,
        S_HOLD_T = 3'd5
    } state_e;

    function automatic logic is_comm(input state_e s);
        return (s == S_COMM_F) || (s == S_COMM_T);
    endfunction

endpackage

// File: rtl/comm_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module comm_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of its inputs, regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/comm_ctrl.sv
// Session controller: picks the fibonacci or timer generator, forwards its words
// to the CDC buffer, pauses on full, drains on stop. Optional: COMM_CTRL_PARITY_EN.
module comm_ctrl
    import comm_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop_f_t,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_out,
    input  logic              t_valid,
    input  logic [DATA_W-1:0] t_out,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    input  logic              data_2_valid,
    output logic              f_en,
    output logic              t_en,
    output logic [DATA_W-1:0] data_1,
    output logic              data_1_en,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              parity
);

    state_e            state_q, state_d;
    logic              f_en_d, t_en_d;
    logic              push_d, drop_d;
    logic [DATA_W-1:0] data_d;
    logic              leave_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_f)      state_d = S_COMM_F;
                else if (start_t) state_d = S_COMM_T;
            end
            S_COMM_F: begin
                if (stop_f_t)         state_d = S_DRAIN;
                else if (buffer_full) state_d = S_HOLD_F;
            end
            S_COMM_T: begin
                if (stop_f_t)         state_d = S_DRAIN;
                else if (buffer_full) state_d = S_HOLD_T;
            end
            S_HOLD_F: begin
                if (stop_f_t)          state_d = S_DRAIN;
                else if (!buffer_full) state_d = S_COMM_F;
            end
            S_HOLD_T: begin
                if (stop_f_t)          state_d = S_DRAIN;
                else if (!buffer_full) state_d = S_COMM_T;
            end
            S_DRAIN: begin
                if (buffer_empty && !data_2_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables follow the next state so they line up with the registered state bus;
    // push/drop follow the current state so a valid is pushed one cycle later.
    always_comb begin
        f_en_d = (state_d == S_COMM_F);
        t_en_d = (state_d == S_COMM_T);
        push_d = 1'b0;
        drop_d = 1'b0;
        data_d = data_1;
        if (state_q == S_COMM_F) begin
            data_d = f_out;
            push_d = f_valid & ~buffer_full;
            drop_d = f_valid &  buffer_full;
        end else if (state_q == S_COMM_T) begin
            data_d = t_out;
            push_d = t_valid & ~buffer_full;
            drop_d = t_valid &  buffer_full;
        end
    end

    assign leave_idle = (state_q == S_IDLE) && (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_en      <= 1'b0;
            t_en      <= 1'b0;
            data_1    <= '0;
            data_1_en <= 1'b0;
        end else begin
            f_en      <= f_en_d;
            t_en      <= t_en_d;
            data_1    <= data_d;
            data_1_en <= push_d;
        end
    end

    assign state = state_q;

    comm_ctrl_sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .clr (leave_idle),
        .inc (push_d),
        .cnt (word_cnt)
    );

    comm_ctrl_sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .clr (leave_idle),
        .inc (drop_d & is_comm(state_q)),
        .cnt (drop_cnt)
    );

`ifdef COMM_CTRL_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (leave_idle) begin
            parity_q <= 1'b0;
        end else if (push_d) begin
            parity_q <= parity_q ^ (^data_d);
        end
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule
